hex_display_arbiter: RTL and testbench

//  Shares the single 4-digit hex display (hex_display driver) between NREQ

---
 rtl/hex_display_arbiter.sv | 99 +++++++++
 tb/tb_hex_display_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter that shares one 4-digit hex display among NREQ producers.
// Each accepted value is held on screen for HOLD_CYCLES; the display blanks after BLANK_CYCLES of idle time.
module hex_display_arbiter #(
  parameter int NREQ         = 4,
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLANK_CYCLES = 250_000_000
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          disp_data,
  output logic [2:0]           disp_owner,
  output logic                 disp_blank,
  output logic                 busy
);

  localparam int TMAX = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   rr_next;
  logic            found;
  logic [15:0]     data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[16*g +: 16];
  end

  // Rotating priority search: first valid requester at or after rr_ptr.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    rr_next = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      automatic int unsigned idx = (32'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[IW'(idx)]) begin
        found   = 1'b1;
        win     = IW'(idx);
        rr_next = IW'((idx + 1) % NREQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found)
      req_ready = NREQ'(1) << win;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      timer      <= '0;
      rr_ptr     <= '0;
      disp_data  <= '0;
      disp_owner <= '0;
      disp_blank <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // An accept takes precedence over the idle timer expiring.
          if (found) begin
            disp_data  <= data_arr[win];
            disp_owner <= 3'(win);
            disp_blank <= 1'b0;
            busy       <= 1'b1;
            rr_ptr     <= rr_next;
            timer      <= TW'(HOLD_CYCLES - 1);
            state      <= HOLD;
          end else if (timer == '0) begin
            disp_blank <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        HOLD: begin
          if (timer == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            timer <= TW'(BLANK_CYCLES - 1);
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter: directed scenarios plus random traffic
// compared every cycle against a cycle-count reference model.
module tb_hex_display_arbiter;

  localparam int NREQ  = 3;
  localparam int HOLD  = 4;
  localparam int BLANK = 6;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  req_valid;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic [15:0] disp_data;
  logic [2:0]  disp_owner;
  logic        disp_blank;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  hex_display_arbiter #(
    .NREQ(NREQ),
    .HOLD_CYCLES(HOLD),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .disp_data(disp_data),
    .disp_owner(disp_owner),
    .disp_blank(disp_blank),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: counts cycles spent showing a value and cycles spent idle.
  bit          m_in_hold;
  int          m_hold_cnt;
  int          m_idle_cnt;
  int          m_rr;
  logic [15:0] m_data;
  int          m_owner;
  bit          m_blank;
  int          grant_log[$];

  function automatic void model_reset();
    m_in_hold  = 1'b0;
    m_hold_cnt = 0;
    m_idle_cnt = BLANK;
    m_rr       = 0;
    m_data     = 16'h0000;
    m_owner    = 0;
    m_blank    = 1'b1;
  endfunction

  function automatic int model_winner();
    int v;
    v = int'(req_valid);
    if (m_in_hold) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_rr + k) % NREQ;
      if (((v >> i) & 1) == 1) return i;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    int w;
    logic [2:0] exp_ready;
    @(negedge CLK);
    w = model_winner();
    exp_ready = (w >= 0) ? 3'(1 << w) : 3'b000;
    check("req_ready",  32'(req_ready),  32'(exp_ready));
    check("disp_data",  32'(disp_data),  32'(m_data));
    check("disp_owner", 32'(disp_owner), 32'(m_owner));
    check("disp_blank", 32'(disp_blank), 32'(m_blank));
    check("busy",       32'(busy),       32'(m_in_hold));
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else if (w >= 0) begin
      m_data     = 16'(req_data >> (16 * w));
      m_owner    = w;
      m_blank    = 1'b0;
      m_in_hold  = 1'b1;
      m_hold_cnt = 0;
      m_rr       = (w + 1) % NREQ;
      grant_log.push_back(w);
    end else if (m_in_hold) begin
      m_hold_cnt++;
      if (m_hold_cnt == HOLD) begin
        m_in_hold  = 1'b0;
        m_idle_cnt = 0;
      end
    end else begin
      if (m_idle_cnt < BLANK) m_idle_cnt++;
      if (m_idle_cnt >= BLANK) m_blank = 1'b1;
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    req_valid = 3'b000;
    req_data  = '0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    RST = 1'b0;

    // Idle after reset: blank, zero data, no grants.
    steps(20);
    check("post_reset_blank", 32'(disp_blank), 32'd1);

    // Single requester held valid: re-granted every HOLD+1 cycles.
    req_data  = {16'h3333, 16'h2222, 16'hCAFE};
    req_valid = 3'b001;
    steps(12);
    req_valid = 3'b000;
    steps(3);

    // All three valid: strict round-robin from requester 0.
    pulse_reset();
    grant_log.delete();
    req_data  = {16'h3333, 16'h2222, 16'h1111};
    req_valid = 3'b111;
    steps(16);
    req_valid = 3'b000;
    check("rr_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() >= 4) begin
      check("rr_grant0", 32'(grant_log[0]), 32'd0);
      check("rr_grant1", 32'(grant_log[1]), 32'd1);
      check("rr_grant2", 32'(grant_log[2]), 32'd2);
      check("rr_grant3", 32'(grant_log[3]), 32'd0);
    end
    steps(5);

    // Blanking after idle timeout, data retained, new accept unblanks.
    pulse_reset();
    req_data  = {16'h3333, 16'h1234, 16'hBEEF};
    req_valid = 3'b001;
    step();
    req_valid = 3'b000;
    steps(12);
    check("blank_after_idle", 32'(disp_blank), 32'd1);
    check("data_kept_beef",   32'(disp_data),  32'h0000BEEF);
    req_valid = 3'b010;
    step();
    req_valid = 3'b000;
    steps(3);

    // Request raised during owner 1's hold is granted in the first IDLE cycle.
    req_data  = {16'h5A5A, 16'h4444, 16'h0000};
    req_valid = 3'b010;
    steps(6);
    req_valid = 3'b100;
    steps(4);
    req_valid = 3'b000;
    steps(6);

    // Reset mid-hold: in-flight value dropped, priority returns to requester 0.
    req_data  = {16'h7777, 16'h6666, 16'h9999};
    req_valid = 3'b001;
    step();
    req_valid = 3'b000;
    step();
    pulse_reset();
    grant_log.delete();
    req_valid = 3'b011;
    step();
    req_valid = 3'b010;
    steps(5);
    req_valid = 3'b000;
    steps(3);
    check("rst_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      check("rst_grant0", 32'(grant_log[0]), 32'd0);
      check("rst_grant1", 32'(grant_log[1]), 32'd1);
    end

    // Random traffic; data of a requester changes only while it is not offering.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] nv;
      nv = 3'($urandom_range(0, 7));
      if ((n % 3) == 0) nv = 3'b000;
      for (int i = 0; i < NREQ; i++) begin
        if (((int'(req_valid) >> i) & 1) == 0)
          req_data[16*i +: 16] = 16'($urandom);
      end
      req_valid = nv;
      RST = ($urandom_range(0, 63) == 0);
      step();
      RST = 1'b0;
    end
    req_valid = 3'b000;
    steps(12);
    check("final_blank", 32'(disp_blank), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
